// File: rtl/mig_app_pkg.sv
// mig_app_pkg: command codes, FSM states and beat pattern shared by the traffic generator
package mig_app_pkg;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_CAL, S_WRITE, S_READ, S_DONE} tg_state_t;
  function automatic logic [31:0] pattern(input logic [15:0] i);
    return {i, ~i};
  endfunction
endpackage

// File: rtl/mig_tg_checker.sv
// mig_tg_checker: compares returned beats with the pattern, counts errors, captures first failing address
module mig_tg_checker
  import mig_app_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic [15:0]               i_beat,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  input  logic [APP_DATA_WIDTH-1:0] i_data,
  output logic [15:0]               o_err_count,
  output logic [ADDR_WIDTH-1:0]     o_first_err_addr
);
  logic [15:0]           r_err_count;
  logic [ADDR_WIDTH-1:0] r_first_err_addr;
  logic                  w_mismatch;
  assign w_mismatch = i_valid && (i_data != {(APP_DATA_WIDTH/32){pattern(i_beat)}});
  assign o_err_count = r_err_count;
  assign o_first_err_addr = r_first_err_addr;
  // a zero count doubles as "no error seen yet" because the count saturates instead of wrapping
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_err_count <= '0;
      r_first_err_addr <= '0;
    end else if (i_clear) begin
      r_err_count <= '0;
      r_first_err_addr <= '0;
    end else if (w_mismatch) begin
      if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
      if (r_err_count == '0) r_first_err_addr <= i_addr;
    end
endmodule

// File: rtl/mig_app_traffic_gen.sv
// mig_app_traffic_gen: app-interface self-test master: write a pattern, read it back, report pass/fail
module mig_app_traffic_gen
  import mig_app_pkg::*;
#(
  parameter int ADDR_WIDTH     = 28,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int NUM_BEATS      = 256,
  parameter int ADDR_STEP      = 8,
  parameter int START_ADDR     = 0,
  parameter int TIMEOUT        = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      init_calib_complete,
  input  logic                      start,
  input  logic                      app_rdy,
  input  logic                      app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
  input  logic                      app_rd_data_valid,
  input  logic                      app_rd_data_end,
  output logic [ADDR_WIDTH-1:0]     app_addr,
  output logic [2:0]                app_cmd,
  output logic                      app_en,
  output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  output logic                      app_wdf_wren,
  output logic                      app_wdf_end,
  output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [15:0]               err_count,
  output logic [ADDR_WIDTH-1:0]     first_err_addr
);
  localparam int CW = 17;
  localparam logic [CW-1:0]         L_N     = CW'(NUM_BEATS);
  localparam logic [31:0]           L_TO    = 32'(TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] L_START = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] L_STEP  = ADDR_WIDTH'(ADDR_STEP);
  tg_state_t             r_state, w_next;
  logic [CW-1:0]         r_wc, r_wd, r_rc, r_rd, w_idx;
  logic [31:0]           r_wdog;
  logic                  r_timeout, r_abort;
  logic                  w_start, w_cmd_acc, w_wdf_acc, w_rd_acc, w_abort, w_stall, w_unused;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  assign w_unused  = app_rd_data_end;
  assign w_start   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_cmd_acc = app_en && app_rdy;
  assign w_wdf_acc = app_wdf_wren && app_wdf_rdy;
  assign w_rd_acc  = app_rd_data_valid && r_state == S_READ && r_rd < L_N;
  assign w_abort   = !init_calib_complete && (r_state == S_WRITE || r_state == S_READ);
  assign w_stall   = r_state == S_READ && !w_cmd_acc && !app_rd_data_valid && r_wdog == L_TO;
  always_comb begin
    w_next = r_state;
    if (w_start) w_next = S_WAIT_CAL;
    else if (w_abort || w_stall) w_next = S_DONE;
    else if (r_state == S_WAIT_CAL && init_calib_complete) w_next = S_WRITE;
    else if (r_state == S_WRITE && r_wc == L_N && r_wd == L_N) w_next = S_READ;
    else if (r_state == S_READ && r_rd == L_N) w_next = S_DONE;
  end
  assign app_en       = (r_state == S_WRITE && r_wc < L_N) || (r_state == S_READ && r_rc < L_N);
  assign app_cmd      = r_state == S_READ ? CMD_READ : CMD_WRITE;
  assign w_idx        = r_state == S_READ ? r_rc : r_wc;
  assign app_addr     = app_en ? L_START + ADDR_WIDTH'(w_idx) * L_STEP : '0;
  assign app_wdf_wren = r_state == S_WRITE && r_wd < L_N && r_wd <= r_wc;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = app_wdf_wren ? {(APP_DATA_WIDTH/32){pattern(r_wd[15:0])}} : '0;
  assign app_wdf_mask = '0;
  assign busy         = !(r_state == S_IDLE || r_state == S_DONE);
  assign done         = r_state == S_DONE;
  assign pass         = done && err_count == '0 && !r_timeout && !r_abort;
  assign timeout      = r_timeout;
  assign w_rd_addr    = L_START + ADDR_WIDTH'(r_rd) * L_STEP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wc <= '0;
      r_wd <= '0;
      r_rc <= '0;
      r_rd <= '0;
      r_wdog <= '0;
      r_timeout <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_wc <= '0;
        r_wd <= '0;
        r_rc <= '0;
        r_rd <= '0;
        r_timeout <= 1'b0;
        r_abort <= 1'b0;
      end else begin
        if (w_cmd_acc && r_state == S_WRITE) r_wc <= r_wc + 1'b1;
        if (w_cmd_acc && r_state == S_READ) r_rc <= r_rc + 1'b1;
        if (w_wdf_acc) r_wd <= r_wd + 1'b1;
        if (w_rd_acc) r_rd <= r_rd + 1'b1;
        if (w_stall) r_timeout <= 1'b1;
        if (w_abort) r_abort <= 1'b1;
      end
      r_wdog <= (r_state != S_READ || w_cmd_acc || app_rd_data_valid) ? '0 : r_wdog + 32'd1;
    end
  mig_tg_checker #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .APP_DATA_WIDTH(APP_DATA_WIDTH)
  ) u_checker (
    .clk(clk),
    .rst_n(rst_n),
    .i_clear(w_start),
    .i_valid(w_rd_acc),
    .i_beat(r_rd[15:0]),
    .i_addr(w_rd_addr),
    .i_data(app_rd_data),
    .o_err_count(err_count),
    .o_first_err_addr(first_err_addr)
  );
endmodule
